pattern_sweep_checker: RTL and testbench

Self-checking exhaustive stimulus engine for N-input combinational gates. On start it drives all 2^N_INPUTS input vectors onto a device under test and samples the device's single output after a programmable dwell. Each sample is compared against a built-in reference for the selected gate function. Errors are counted and the first failing vector is captured. The block sits beside gate instances in the gate-library regression harness, in synthesizable form usable on-chip as a BIST-style sweeper.

---
 rtl/pattern_sweep_pkg.sv | 18 +
 rtl/sweep_ref_model.sv | 26 ++
 rtl/pattern_sweep_checker.sv | 185 ++++++++++++++++++
 tb/tb_pattern_sweep_checker.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pattern_sweep_pkg.sv
// Shared definitions for the exhaustive gate pattern sweeper:
// reference-function mode encodings and the sweep FSM state type.
package pattern_sweep_pkg;

  // Reference function selection, latched at an accepted start.
  localparam logic [1:0] MODE_AND  = 2'd0;
  localparam logic [1:0] MODE_OR   = 2'd1;
  localparam logic [1:0] MODE_XOR  = 2'd2;
  localparam logic [1:0] MODE_NAND = 2'd3;

  // Sweep controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sweep_ref_model.sv
// Combinational golden model of the gate under test. Given the selected
// reference function and the applied input vector it returns the bit the
// device should produce. Kept standalone so benches can reuse it.
module sweep_ref_model
  import pattern_sweep_pkg::*;
#(
  parameter int N_INPUTS = 5
) (
  input  logic [1:0]          mode,
  input  logic [N_INPUTS-1:0] stim,
  output logic                expected
);

  // Evaluate the selected N-input reduction over the applied vector.
  always_comb begin
    expected = 1'b0;
    case (mode)
      MODE_AND:  expected = &stim;
      MODE_OR:   expected = |stim;
      MODE_XOR:  expected = ^stim;
      MODE_NAND: expected = ~&stim;
      default:   expected = 1'b0;
    endcase
  end

endmodule

// File: rtl/pattern_sweep_checker.sv
// Exhaustive stimulus engine for N-input combinational gates. An accepted
// start walks every input vector, holds each for DWELL cycles, samples the
// device output on the last dwell cycle and compares it with the built-in
// reference. Mismatches are counted (saturating) and the first failing
// vector is captured.
// Optional build macro SWEEP_GRAY_EN: vectors are driven in Gray order
// (one input toggles per step) instead of binary ascending order.
module pattern_sweep_checker
  import pattern_sweep_pkg::*;
#(
  parameter int N_INPUTS = 5,
  parameter int DWELL    = 4,
  parameter int ERR_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic                dut_o,
  output logic [N_INPUTS-1:0] stim,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERR_W-1:0]    err_count,
  output logic                fail_valid,
  output logic [N_INPUTS-1:0] fail_vec
);

  // Index carries one extra bit so the count past the last vector is
  // distinguishable from vector 0.
  localparam int IDX_W = N_INPUTS + 1;
  localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(1 << N_INPUTS);
  localparam logic [DW_W-1:0]  DW_LAST = DW_W'(DWELL - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  // Map a sweep index onto the vector actually driven.
  function automatic logic [N_INPUTS-1:0] vec_of(input logic [N_INPUTS-1:0] idx);
`ifdef SWEEP_GRAY_EN
    return idx ^ (idx >> 1'b1);
`else
    return idx;
`endif
  endfunction

  state_t               state_r, state_nxt_s;
  logic [IDX_W-1:0]     idx_r, idx_nxt_s, idx_inc_s;
  logic [DW_W-1:0]      dwell_r, dwell_nxt_s;
  logic [1:0]           mode_r, mode_nxt_s;
  logic [N_INPUTS-1:0]  stim_r, stim_nxt_s;
  logic [ERR_W-1:0]     err_r, err_nxt_s;
  logic                 fail_valid_r, fail_valid_nxt_s;
  logic [N_INPUTS-1:0]  fail_vec_r, fail_vec_nxt_s;
  logic                 busy_r, busy_nxt_s;
  logic                 done_r, done_nxt_s;
  logic                 pass_r, pass_nxt_s;
  logic                 accept_s, sample_s, last_s, expected_s, mismatch_s;

  sweep_ref_model #(
    .N_INPUTS (N_INPUTS)
  ) u_ref (
    .mode     (mode_r),
    .stim     (stim_r),
    .expected (expected_s)
  );

  // A start is honoured only when no sweep is running.
  assign accept_s   = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign sample_s   = (state_r == ST_APPLY) && (dwell_r == DW_LAST);
  assign idx_inc_s  = idx_r + IDX_W'(1'b1);
  assign last_s     = sample_s && (idx_inc_s == IDX_END);
  assign mismatch_s = (dut_o != expected_s);

  // FSM state register; rst overrides everything, including a running sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state: start launches a sweep, final sample ends it.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_APPLY;
        else       state_nxt_s = ST_IDLE;
      end
      ST_APPLY: begin
        if (last_s) state_nxt_s = ST_DONE;
        else        state_nxt_s = ST_APPLY;
      end
      ST_DONE: begin
        if (start) state_nxt_s = ST_APPLY;
        else       state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs and datapath next values: dwell/index stepping, checking,
  // error counting and first-failure capture.
  always_comb begin
    idx_nxt_s        = idx_r;
    dwell_nxt_s      = dwell_r;
    mode_nxt_s       = mode_r;
    stim_nxt_s       = stim_r;
    err_nxt_s        = err_r;
    fail_valid_nxt_s = fail_valid_r;
    fail_vec_nxt_s   = fail_vec_r;
    if (accept_s) begin
      mode_nxt_s       = mode;
      idx_nxt_s        = {IDX_W{1'b0}};
      dwell_nxt_s      = {DW_W{1'b0}};
      stim_nxt_s       = vec_of({N_INPUTS{1'b0}});
      err_nxt_s        = {ERR_W{1'b0}};
      fail_valid_nxt_s = 1'b0;
      fail_vec_nxt_s   = {N_INPUTS{1'b0}};
    end else if (sample_s) begin
      dwell_nxt_s = {DW_W{1'b0}};
      idx_nxt_s   = idx_inc_s;
      if (mismatch_s) begin
        if (err_r != ERR_MAX) err_nxt_s = err_r + ERR_W'(1'b1);
        else                  err_nxt_s = err_r;
        if (!fail_valid_r) begin
          fail_valid_nxt_s = 1'b1;
          fail_vec_nxt_s   = stim_r;
        end else begin
          fail_valid_nxt_s = fail_valid_r;
          fail_vec_nxt_s   = fail_vec_r;
        end
      end else begin
        err_nxt_s = err_r;
      end
      // The last vector stays on the bus once the sweep completes.
      if (last_s) stim_nxt_s = stim_r;
      else        stim_nxt_s = vec_of(idx_inc_s[N_INPUTS-1:0]);
    end else if (state_r == ST_APPLY) begin
      dwell_nxt_s = dwell_r + DW_W'(1'b1);
    end else begin
      dwell_nxt_s = dwell_r;
    end
    busy_nxt_s = (state_nxt_s == ST_APPLY);
    done_nxt_s = (state_nxt_s == ST_DONE);
    pass_nxt_s = done_nxt_s && (err_nxt_s == {ERR_W{1'b0}});
  end

  // Datapath and output registers, all cleared by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r        <= {IDX_W{1'b0}};
      dwell_r      <= {DW_W{1'b0}};
      mode_r       <= MODE_AND;
      stim_r       <= {N_INPUTS{1'b0}};
      err_r        <= {ERR_W{1'b0}};
      fail_valid_r <= 1'b0;
      fail_vec_r   <= {N_INPUTS{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      pass_r       <= 1'b0;
    end else begin
      idx_r        <= idx_nxt_s;
      dwell_r      <= dwell_nxt_s;
      mode_r       <= mode_nxt_s;
      stim_r       <= stim_nxt_s;
      err_r        <= err_nxt_s;
      fail_valid_r <= fail_valid_nxt_s;
      fail_vec_r   <= fail_vec_nxt_s;
      busy_r       <= busy_nxt_s;
      done_r       <= done_nxt_s;
      pass_r       <= pass_nxt_s;
    end
  end

  assign stim       = stim_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign pass       = pass_r;
  assign err_count  = err_r;
  assign fail_valid = fail_valid_r;
  assign fail_vec   = fail_vec_r;

endmodule

// File: tb/tb_pattern_sweep_checker.sv
// Bench for pattern_sweep_checker. Three instances: A (5 inputs, dwell 4),
// B (5 inputs, dwell 4, 3-bit saturating counter), C (3 inputs, dwell 1).
// Expected sweep outcomes are predicted by an independent model and queued
// when a start is driven; they are popped and compared when done rises.
module tb_pattern_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_a, start_b, start_c;
  logic [1:0] mode_a, mode_b, mode_c;
  logic       dut_o_a, dut_o_b, dut_o_c;
  logic [4:0] stim_a, stim_b, fvec_a, fvec_b;
  logic [2:0] stim_c, fvec_c;
  logic       busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic       pass_a, pass_b, pass_c, fv_a, fv_b, fv_c;
  logic [7:0] err_a, err_c;
  logic [2:0] err_b;

  // Device-model control: 0 correct gate, 1 stuck at 0, 2 stuck at 1.
  int         fault_a, fault_b;
  logic [1:0] gold_mode_a, gold_mode_b, gold_mode_c;

  typedef struct {
    int         cycles;
    int         err;
    logic       fv;
    logic [4:0] fvec;
    logic       pass;
  } exp_t;

  exp_t       sb_q[$];
  logic [2:0] stim_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  // Order in which the sweeper is expected to drive vectors.
  function automatic logic [15:0] order(input int i);
`ifdef SWEEP_GRAY_EN
    return 16'(i ^ (i >> 1));
`else
    return 16'(i);
`endif
  endfunction

  function automatic logic gold(input logic [1:0] m, input logic [15:0] v, input int n);
    logic [15:0] mask;
    logic [15:0] x;
    mask = 16'((1 << n) - 1);
    x    = v & mask;
    case (m)
      2'd0:    return x == mask;
      2'd1:    return x != 16'd0;
      2'd2:    return ^x;
      default: return x != mask;
    endcase
  endfunction

  function automatic exp_t predict(input logic [1:0] m, input int fault, input int n,
                                   input int dwell, input int errmax);
    exp_t e;
    logic [15:0] v;
    logic r, d;
    e.cycles = (1 << n) * dwell + 1;
    e.err = 0; e.fv = 1'b0; e.fvec = 5'd0;
    for (int i = 0; i < (1 << n); i++) begin
      v = order(i);
      r = gold(m, v, n);
      d = (fault == 0) ? r : ((fault == 1) ? 1'b0 : 1'b1);
      if (d != r) begin
        if (e.err < errmax) e.err++;
        if (!e.fv) begin e.fv = 1'b1; e.fvec = v[4:0]; end
      end
    end
    e.pass = (e.err == 0);
    return e;
  endfunction

  always_comb dut_o_a = (fault_a == 0) ? gold(gold_mode_a, {11'd0, stim_a}, 5) : (fault_a == 2);
  always_comb dut_o_b = (fault_b == 0) ? gold(gold_mode_b, {11'd0, stim_b}, 5) : (fault_b == 2);
  always_comb dut_o_c = gold(gold_mode_c, {13'd0, stim_c}, 3);

  pattern_sweep_checker #(.N_INPUTS(5), .DWELL(4), .ERR_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mode(mode_a), .dut_o(dut_o_a),
    .stim(stim_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .fail_valid(fv_a), .fail_vec(fvec_a));

  pattern_sweep_checker #(.N_INPUTS(5), .DWELL(4), .ERR_W(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .mode(mode_b), .dut_o(dut_o_b),
    .stim(stim_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .fail_valid(fv_b), .fail_vec(fvec_b));

  pattern_sweep_checker #(.N_INPUTS(3), .DWELL(1), .ERR_W(8)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .mode(mode_c), .dut_o(dut_o_c),
    .stim(stim_c), .busy(busy_c), .done(done_c), .pass(pass_c),
    .err_count(err_c), .fail_valid(fv_c), .fail_vec(fvec_c));

  // Pulse start on A for one cycle; returns just after the accepting edge.
  task automatic pulse_start_a(input logic [1:0] m);
    @(negedge clk);
    mode_a = m; gold_mode_a = m; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  // Wait for A's done, counting edges from the accepting edge; optionally
  // re-pulse start (with another mode) at two cycle numbers mid-sweep.
  task automatic wait_done_a(input int inj1, input int inj2, input logic [1:0] inj_mode,
                             output int cyc);
    cyc = 1;
    while (done_a !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      start_a = 1'b0;
      cyc++;
      if (cyc == inj1 || cyc == inj2) begin
        start_a = 1'b1; mode_a = inj_mode;
      end
    end
    start_a = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (stim_a !== 5'd0) $display("FAIL reset.stim got=%0d want=0", stim_a); else n_pass++;
    n_checks++; if (busy_a !== 1'b0) $display("FAIL reset.busy got=%b want=0", busy_a); else n_pass++;
    n_checks++; if (done_a !== 1'b0) $display("FAIL reset.done got=%b want=0", done_a); else n_pass++;
    n_checks++; if (pass_a !== 1'b0) $display("FAIL reset.pass got=%b want=0", pass_a); else n_pass++;
    n_checks++; if (err_a !== 8'd0) $display("FAIL reset.err got=%0d want=0", err_a); else n_pass++;
    n_checks++; if (fv_a !== 1'b0) $display("FAIL reset.fail_valid got=%b want=0", fv_a); else n_pass++;
    n_checks++; if (fvec_a !== 5'd0) $display("FAIL reset.fail_vec got=%0d want=0", fvec_a); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_and_pass;
    int cyc;
    exp_t e;
    fault_a = 0;
    sb_q.push_back(predict(2'd0, 0, 5, 4, 255));
    pulse_start_a(2'd0);
    n_checks++; if (busy_a !== 1'b1) $display("FAIL and.busy_after_start got=%b want=1", busy_a); else n_pass++;
    wait_done_a(-1, -1, 2'd0, cyc);
    e = sb_q.pop_front();
    n_checks++; if (cyc !== e.cycles) $display("FAIL and.latency got=%0d want=%0d", cyc, e.cycles); else n_pass++;
    n_checks++; if (int'(err_a) !== e.err) $display("FAIL and.err got=%0d want=%0d", err_a, e.err); else n_pass++;
    n_checks++; if (fv_a !== e.fv) $display("FAIL and.fail_valid got=%b want=%b", fv_a, e.fv); else n_pass++;
    n_checks++; if (pass_a !== e.pass) $display("FAIL and.pass got=%b want=%b", pass_a, e.pass); else n_pass++;
    n_checks++; if (busy_a !== 1'b0) $display("FAIL and.busy_at_done got=%b want=0", busy_a); else n_pass++;
  endtask

  task automatic test_or_stuck0;
    int cyc;
    exp_t e;
    fault_a = 1;
    sb_q.push_back(predict(2'd1, 1, 5, 4, 255));
    pulse_start_a(2'd1);
    wait_done_a(-1, -1, 2'd1, cyc);
    e = sb_q.pop_front();
    n_checks++; if (cyc !== e.cycles) $display("FAIL or.latency got=%0d want=%0d", cyc, e.cycles); else n_pass++;
    n_checks++; if (int'(err_a) !== e.err) $display("FAIL or.err got=%0d want=%0d", err_a, e.err); else n_pass++;
    n_checks++; if (fv_a !== e.fv) $display("FAIL or.fail_valid got=%b want=%b", fv_a, e.fv); else n_pass++;
    n_checks++; if (fvec_a !== e.fvec) $display("FAIL or.fail_vec got=%0d want=%0d", fvec_a, e.fvec); else n_pass++;
    n_checks++; if (pass_a !== e.pass) $display("FAIL or.pass got=%b want=%b", pass_a, e.pass); else n_pass++;
    fault_a = 0;
  endtask

  task automatic test_xor_saturate;
    int cyc;
    exp_t e;
    fault_b = 2;
    sb_q.push_back(predict(2'd2, 2, 5, 4, 7));
    @(negedge clk);
    mode_b = 2'd2; gold_mode_b = 2'd2; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    cyc = 1;
    while (done_b !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    e = sb_q.pop_front();
    n_checks++; if (cyc !== e.cycles) $display("FAIL xor.latency got=%0d want=%0d", cyc, e.cycles); else n_pass++;
    n_checks++; if (int'(err_b) !== e.err) $display("FAIL xor.err_sat got=%0d want=%0d", err_b, e.err); else n_pass++;
    n_checks++; if (fv_b !== e.fv) $display("FAIL xor.fail_valid got=%b want=%b", fv_b, e.fv); else n_pass++;
    n_checks++; if (fvec_b !== e.fvec) $display("FAIL xor.fail_vec got=%0d want=%0d", fvec_b, e.fvec); else n_pass++;
    n_checks++; if (pass_b !== e.pass) $display("FAIL xor.pass got=%b want=%b", pass_b, e.pass); else n_pass++;
  endtask

  task automatic test_rst_mid_sweep;
    int cyc;
    exp_t e;
    fault_a = 1;
    pulse_start_a(2'd1);
    for (int c = 1; c < 40; c++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if ({busy_a, done_a, pass_a, fv_a} !== 4'b0000) $display("FAIL rstmid.flags got=%b want=0000", {busy_a, done_a, pass_a, fv_a}); else n_pass++;
    n_checks++; if (err_a !== 8'd0) $display("FAIL rstmid.err got=%0d want=0", err_a); else n_pass++;
    n_checks++; if (stim_a !== 5'd0 || fvec_a !== 5'd0) $display("FAIL rstmid.vec got=%0d/%0d want=0/0", stim_a, fvec_a); else n_pass++;
    @(negedge clk);
    n_checks++; if ({busy_a, done_a} !== 2'b00) $display("FAIL rstmid.idle got=%b want=00", {busy_a, done_a}); else n_pass++;
    fault_a = 0;
    sb_q.push_back(predict(2'd0, 0, 5, 4, 255));
    pulse_start_a(2'd0);
    wait_done_a(-1, -1, 2'd0, cyc);
    e = sb_q.pop_front();
    n_checks++; if (cyc !== e.cycles) $display("FAIL rstmid.latency got=%0d want=%0d", cyc, e.cycles); else n_pass++;
    n_checks++; if (int'(err_a) !== e.err) $display("FAIL rstmid.err_after got=%0d want=%0d", err_a, e.err); else n_pass++;
    n_checks++; if (pass_a !== e.pass) $display("FAIL rstmid.pass got=%b want=%b", pass_a, e.pass); else n_pass++;
  endtask

  task automatic test_start_ignored;
    int cyc;
    exp_t e;
    fault_a = 0;
    sb_q.push_back(predict(2'd0, 0, 5, 4, 255));
    pulse_start_a(2'd0);
    wait_done_a(10, 50, 2'd2, cyc);
    e = sb_q.pop_front();
    n_checks++; if (cyc !== e.cycles) $display("FAIL restart.latency got=%0d want=%0d", cyc, e.cycles); else n_pass++;
    n_checks++; if (int'(err_a) !== e.err) $display("FAIL restart.err got=%0d want=%0d", err_a, e.err); else n_pass++;
    n_checks++; if (fv_a !== e.fv) $display("FAIL restart.fail_valid got=%b want=%b", fv_a, e.fv); else n_pass++;
    n_checks++; if (pass_a !== e.pass) $display("FAIL restart.pass got=%b want=%b", pass_a, e.pass); else n_pass++;
  endtask

  task automatic test_vector_order;
    logic [15:0] t;
    logic [2:0]  want, prev;
    prev = 3'd0;
    for (int i = 0; i < 8; i++) begin
      t = order(i);
      stim_q.push_back(t[2:0]);
    end
    @(negedge clk);
    mode_c = 2'd3; gold_mode_c = 2'd3; start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    for (int k = 0; k < 8; k++) begin
      want = stim_q.pop_front();
      n_checks++; if (stim_c !== want) $display("FAIL order.stim[%0d] got=%0d want=%0d", k, stim_c, want); else n_pass++;
      n_checks++; if ({busy_c, done_c} !== 2'b10) $display("FAIL order.busy[%0d] got=%b want=10", k, {busy_c, done_c}); else n_pass++;
`ifdef SWEEP_GRAY_EN
      if (k > 0) begin
        n_checks++; if ($countones(stim_c ^ prev) !== 1) $display("FAIL order.gray_step[%0d] got=%0d want=1", k, $countones(stim_c ^ prev)); else n_pass++;
      end
`endif
      prev = stim_c;
      @(negedge clk);
    end
    n_checks++; if (done_c !== 1'b1) $display("FAIL order.done_at_9 got=%b want=1", done_c); else n_pass++;
    n_checks++; if (pass_c !== 1'b1) $display("FAIL order.pass got=%b want=1", pass_c); else n_pass++;
    n_checks++; if (stim_c !== prev) $display("FAIL order.stim_hold got=%0d want=%0d", stim_c, prev); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    mode_a = 2'd0; mode_b = 2'd0; mode_c = 2'd0;
    gold_mode_a = 2'd0; gold_mode_b = 2'd0; gold_mode_c = 2'd0;
    fault_a = 0; fault_b = 0;
    test_reset();
    test_and_pass();
    test_or_stuck0();
    test_xor_saturate();
    test_rst_mid_sweep();
    test_start_ignored();
    test_vector_order();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
